// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU scheduler and its users.
package alu_pkg;

    // Datapath width, fixed by the external ALU
    localparam int W = 16;

    // Bit positions inside the 6-bit ALU select {no,f,nb,zb,na,za}
    localparam int ZA = 0;
    localparam int NA = 1;
    localparam int ZB = 2;
    localparam int NB = 3;
    localparam int F  = 4;
    localparam int NO = 5;

    // Flag codes reported by the ALU
    localparam logic [2:0] FLAG_ZERO = 3'd0;
    localparam logic [2:0] FLAG_NEG  = 3'd1;
    localparam logic [2:0] FLAG_POS  = 3'd2;

    // Scheduler phases: arbitrate, drive the ALU, hand back the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above the
// pointer wins, wrapping past the top index back to 0.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int   idx;
    logic found;

    // Scan N positions starting at ptr and grant the first active request
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Time-shares one external combinational ALU between NREQ requesters.
// One operation at a time: accept (IDLE), drive ALU (EXEC), return (RESP).
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*6-1:0] req_sel,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [2:0]        rsp_flag,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [5:0]        alu_sel,
    input  logic [W-1:0]      alu_out,
    input  logic [2:0]        alu_flag,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t    state;
    sched_state_t    state_next;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   grant_idx;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic            release_rsp;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept      = (state == IDLE) && (|grant);
    assign release_rsp = (state == RESP) && rsp_ready[owner];

    // Next-state and handshake outputs; reset masks the combinational ready
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept && !rst) begin
                    req_ready  = grant;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, owner id and fairness pointer (advances past owner on release)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner <= grant_idx;
            end
            if (release_rsp) begin
                ptr <= (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
            end
        end
    end

    // Operand capture on accept, result capture at the end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            rsp_data <= '0;
            rsp_flag <= '0;
        end else begin
            if (accept) begin
                alu_a   <= req_a[int'(grant_idx)*W +: W];
                alu_b   <= req_b[int'(grant_idx)*W +: W];
                alu_sel <= req_sel[int'(grant_idx)*6 +: 6];
            end
            if (state == EXEC) begin
                rsp_data <= alu_out;
                rsp_flag <= alu_flag;
            end
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched with a stub ALU and a
// transaction-level reference model (round-robin pick + arithmetic).
module tb_alu_sched;
    import alu_pkg::*;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0]  req_a, req_b;
    logic [N*6-1:0]  req_sel;
    logic [W-1:0]    rsp_data, alu_a, alu_b, alu_out;
    logic [2:0]      rsp_flag, alu_flag;
    logic [5:0]      alu_sel;
    logic            busy;

    logic [W-1:0]    op_a [N];
    logic [W-1:0]    op_b [N];
    logic [5:0]      op_sel [N];
    int              model_ptr;
    int              total;
    int              bad;

    alu_sched #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flag  (rsp_flag),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_flag  (alu_flag),
        .busy      (busy)
    );

    // Stub ALU: add when f is set, otherwise bitwise and
    assign alu_out  = alu_sel[F] ? alu_a + alu_b : alu_a & alu_b;
    assign alu_flag = (alu_out == '0) ? FLAG_ZERO : (alu_out[W-1] ? FLAG_NEG : FLAG_POS);

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_out(input logic [15:0] a, input logic [15:0] b, input logic [5:0] s);
        int unsigned r;
        if (s[4]) r = (int'(a) + int'(b)) % 65536;
        else      r = int'(a & b);
        return 16'(r);
    endfunction

    function automatic logic [2:0] ref_flag(input logic [15:0] r);
        if (r == 16'd0)        return 3'd0;
        else if ($signed(r) < 0) return 3'd1;
        else                   return 3'd2;
    endfunction

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v);
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W]  = op_a[i];
            req_b[i*W +: W]  = op_b[i];
            req_sel[i*6 +: 6] = op_sel[i];
        end
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, ".rsp_data"},  32'(rsp_data),  32'd0);
        checkOutput({tag, ".rsp_flag"},  32'(rsp_flag),  32'd0);
        checkOutput({tag, ".alu_a"},     32'(alu_a),     32'd0);
        checkOutput({tag, ".alu_b"},     32'(alu_b),     32'd0);
        checkOutput({tag, ".alu_sel"},   32'(alu_sel),   32'd0);
        checkOutput({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    task automatic resetDut(input string tag);
        @(posedge clk); #1;
        rsp_ready = '0;
        applyStimulus('1);
        rst = 1'b1;
        #2;
        checkZeros(tag);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus('0);
        model_ptr = 0;
    endtask

    task automatic idleCheck(input string tag, input logic [15:0] last_a);
        @(posedge clk); #1;
        rsp_ready = '0;
        applyStimulus('0);
        @(negedge clk);
        checkOutput({tag, ".busy"},      32'(busy),      32'd0);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, ".alu_hold"},  32'(alu_a),     32'(last_a));
    endtask

    // One full operation: accept, EXEC, RESP with `hold` stalled cycles, release
    task automatic do_op(input logic [N-1:0] vmask, input logic [N-1:0] stay, input int hold, input string tag);
        int w;
        logic [15:0] er;
        logic [2:0]  ef;
        logic [N-1:0] others;
        w  = pick(vmask);
        er = ref_out(op_a[w], op_b[w], op_sel[w]);
        ef = ref_flag(er);
        @(posedge clk); #1;
        rsp_ready = '0;
        applyStimulus(vmask);
        @(negedge clk);
        checkOutput({tag, ".grant"}, 32'(req_ready), 32'(1) << w);
        checkOutput({tag, ".idle"},  32'(busy), 32'd0);
        @(posedge clk); #1;
        applyStimulus(stay);
        @(negedge clk);
        checkOutput({tag, ".alu_a"},   32'(alu_a),   32'(op_a[w]));
        checkOutput({tag, ".alu_b"},   32'(alu_b),   32'(op_b[w]));
        checkOutput({tag, ".alu_sel"}, 32'(alu_sel), 32'(op_sel[w]));
        checkOutput({tag, ".exec_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, ".exec_rsp"},   32'(rsp_valid), 32'd0);
        checkOutput({tag, ".exec_busy"},  32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(1) << w);
        checkOutput({tag, ".rsp_data"},  32'(rsp_data),  32'(er));
        checkOutput({tag, ".rsp_flag"},  32'(rsp_flag),  32'(ef));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            others = N'($urandom);
            others[w] = 1'b0;
            rsp_ready = others;
            @(negedge clk);
            checkOutput({tag, ".hold_valid"}, 32'(rsp_valid), 32'(1) << w);
            checkOutput({tag, ".hold_data"},  32'(rsp_data),  32'(er));
            checkOutput({tag, ".hold_busy"},  32'(busy), 32'd1);
            checkOutput({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        others = N'($urandom);
        others[w] = 1'b1;
        rsp_ready = others;
        @(negedge clk);
        checkOutput({tag, ".last_valid"}, 32'(rsp_valid), 32'(1) << w);
        checkOutput({tag, ".last_ready"}, 32'(req_ready), 32'd0);
        model_ptr = (w + 1) % N;
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        total     = 0;
        bad       = 0;
        model_ptr = 0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_sel[i] = '0;
        end
        applyStimulus('0);
        repeat (2) @(posedge clk);
        resetDut("reset");

        $display("[TB] single op and backpressure");
        op_a[0] = 16'h0003; op_b[0] = 16'h0004; op_sel[0] = 6'b010000;
        do_op(3'b001, 3'b000, 0, "single");
        idleCheck("single.after", 16'h0003);
        do_op(3'b001, 3'b000, 5, "bp");
        idleCheck("bp.after", 16'h0003);

        $display("[TB] round-robin");
        resetDut("reset2");
        op_a[0] = 16'h8000; op_b[0] = 16'h0001; op_sel[0] = 6'b010000;
        op_a[1] = 16'h00F0; op_b[1] = 16'h0F0F; op_sel[1] = 6'b000000;
        for (int k = 0; k < 4; k++) do_op(3'b011, 3'b011, 0, "rr");

        $display("[TB] pointer wrap and simultaneous request/response");
        do_op(3'b001, 3'b000, 0, "wrap");
        do_op(3'b001, 3'b010, 0, "simul");
        do_op(3'b010, 3'b000, 0, "simul.next");

        $display("[TB] reset during EXEC");
        w = pick(3'b001);
        @(posedge clk); #1;
        rsp_ready = '0;
        applyStimulus(3'b001);
        @(negedge clk);
        checkOutput("midrst.grant", 32'(req_ready), 32'(1) << w);
        @(posedge clk); #1;
        applyStimulus('0);
        #1 rst = 1'b1;
        #1;
        checkZeros("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("midrst.no_rsp", 32'(rsp_valid), 32'd0);
            checkOutput("midrst.busy",   32'(busy), 32'd0);
        end
        op_a[1] = 16'h1234; op_b[1] = 16'h1111; op_sel[1] = 6'b010000;
        do_op(3'b010, 3'b000, 0, "midrst.next");

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                op_a[i]   = W'($urandom);
                op_b[i]   = W'($urandom);
                op_sel[i] = 6'($urandom);
            end
            do_op(N'($urandom_range(1, (1 << N) - 1)), N'($urandom), $urandom_range(0, 3), "rand");
        end
        idleCheck("rand.after", op_a[model_ptr == 0 ? N - 1 : model_ptr - 1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
